mult_iter_pipe: RTL and testbench

//  Parametrised iterative unsigned multiplier for FPAU mantissa products; successor to the combinational mult24 tree.

---
 rtl/mult_iter_pipe_pkg.sv | 25 ++
 rtl/mult_iter_pipe_if.sv | 27 ++
 rtl/mult_iter_pipe_mult_digit.sv | 14 +
 rtl/mult_iter_pipe.sv | 127 ++++++++++++
 tb/tb_mult_iter_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_iter_pipe_pkg.sv
// Shared definitions for the iterative mantissa multiplier.
//   state_t : FSM states of mult_iter_pipe (IDLE, BUSY, DONE)
//   clog2   : width helper for the digit counter; never returns less than 1
//             so a single-iteration configuration still has a legal counter.
package fpau_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mult_iter_pipe_if.sv
// Operand/product handshake bundle for mult_iter_pipe.
//   in_valid/in_ready/in_a/in_b : operand pair, producer -> multiplier
//   out_valid/out_ready/out_p   : product, multiplier -> consumer
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both 1. Once valid is raised, the sender holds
// valid and data stable until that transfer; ready may change freely.
interface mult_iter_pipe_if #(
  parameter int WIDTH = 24
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p
  );
endinterface

// File: rtl/mult_iter_pipe_mult_digit.sv
// Combinational WIDTH x DIGIT unsigned multiply used once per iteration.
//   a_i : multiplicand (WIDTH bits)
//   d_i : one digit of the multiplier (DIGIT bits)
//   p_o : full-width product (WIDTH+DIGIT bits, cannot overflow)
module mult_digit #(
  parameter int WIDTH = 24,
  parameter int DIGIT = 6
) (
  input  logic [WIDTH-1:0]       a_i,
  input  logic [DIGIT-1:0]       d_i,
  output logic [WIDTH+DIGIT-1:0] p_o
);
  assign p_o = (WIDTH+DIGIT)'(a_i) * (WIDTH+DIGIT)'(d_i);
endmodule

// File: rtl/mult_iter_pipe.sv
// Iterative unsigned multiplier: retires DIGIT bits of B per clock and
// accumulates shifted A*digit partial products into a 2*WIDTH product.
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   flush       : synchronous abort, returns to IDLE and drops any product
//   bus (slave) : operand and product valid/ready channels
//   busy        : high while an operation is in BUSY or DONE
//   dbg_state_o : current FSM state for observation
module mult_iter_pipe
  import fpau_mult_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DIGIT = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  mult_iter_pipe_if.slave        bus,
  output logic                   busy,
  output state_t                 dbg_state_o
);

  localparam int NITER = WIDTH / DIGIT;
  localparam int CNT_W = clog2(NITER);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NITER - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("mult_iter_pipe: WIDTH must be a multiple of DIGIT");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic [DIGIT-1:0]       digit;
  logic [WIDTH+DIGIT-1:0] pp;
  logic [2*WIDTH-1:0]     pp_ext;
  logic [2*WIDTH-1:0]     acc_sum;

  // Digit cnt of B, weighted by its position before adding to the sum.
  assign digit = b_q[int'(cnt_q)*DIGIT +: DIGIT];

  mult_digit #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_digit (
    .a_i (a_q),
    .d_i (digit),
    .p_o (pp)
  );

  always_comb begin
    pp_ext = '0;
    pp_ext[WIDTH+DIGIT-1:0] = pp;
  end

  assign acc_sum = acc_q + (pp_ext << (int'(cnt_q) * DIGIT));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    a_d           = a_q;
    b_d           = b_q;
    acc_d         = acc_q;
    p_d           = p_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A flush in the same cycle blocks acceptance of the operand.
        bus.in_ready = ~flush;
        if (bus.in_valid && !flush) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // out_p is a separate register so it can keep the previous
          // product visible while the next operation accumulates.
          p_d     = acc_sum;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      p_d     = p_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

  assign bus.out_p   = p_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mult_iter_pipe.sv
module tb_mult_iter_pipe;
  import fpau_mult_pkg::*;

  localparam int W = 24;
  localparam int D = 6;
  localparam int N = W / D;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic rst_x;
  logic flush;
  logic busy;
  state_t dbg_state;
  bit stop_x = 1'b0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mult_iter_pipe_if #(.WIDTH(W)) bus ();

  mult_iter_pipe #(.WIDTH(W), .DIGIT(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bus),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard helpers ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic logic [63:0] pick(input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 9))
      0:       return 64'd0;
      1:       return mask;
      default: return {$urandom(), $urandom()} & mask;
    endcase
  endfunction

  // ---------------- reference model + compare (main DUT) ----------------
  // Each accepted pair becomes a product a*b that must be presented
  // NITER edges after acceptance and held until taken; flush/reset drop it.
  logic [2*W-1:0] exp_q[$];
  int             due_q[$];
  logic [2*W-1:0] last_p = '0;
  bit             m_idle, m_valid;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      due_q.delete();
      last_p = '0;
      check("rst out_valid", 128'(bus.out_valid), 128'(0));
      check("rst out_p", 128'(bus.out_p), 128'(0));
      check("rst busy", 128'(busy), 128'(0));
    end else begin
      m_idle  = (exp_q.size() == 0);
      m_valid = !m_idle && (cyc >= due_q[0]);
      if (m_valid) last_p = exp_q[0];
      check("out_valid", 128'(bus.out_valid), 128'(m_valid));
      check("out_p", 128'(bus.out_p), 128'(last_p));
      check("in_ready", 128'(bus.in_ready), 128'(m_idle && !flush));
      check("busy", 128'(busy), 128'(!m_idle));
      if (flush) begin
        exp_q.delete();
        due_q.delete();
      end else begin
        if (m_valid && bus.out_ready) begin
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
        if (m_idle && bus.in_valid) begin
          exp_q.push_back((2*W)'(bus.in_a) * (2*W)'(bus.in_b));
          due_q.push_back(cyc + 1 + N);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present an operand pair; returns 1 ns after the accepting edge with
  // the operand inputs scrambled (they must have been latched).
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      @(posedge clk);
      #1;
    end
    if (k == 50) fail_now("send accept");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom());
    bus.in_b     = W'($urandom());
  endtask

  // Send one pair with out_ready high and pin the literal result and latency.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_p);
    int k;
    send(a, b);
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    if (k == 30) fail_now({name, " out_valid"});
    else begin
      check({name, " latency"}, 128'(k), 128'(4));
      check({name, " product"}, 128'(bus.out_p), 128'(exp_p));
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- extra parameterisations ----------------
  function automatic int cfg_w(input int g);
    case (g)
      0: return 24;
      1: return 8;
      2: return 53;
      default: return 32;
    endcase
  endfunction

  function automatic int cfg_d(input int g);
    case (g)
      0: return 24;
      1: return 1;
      2: return 1;
      default: return 8;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int XW = cfg_w(g);
    localparam int XD = cfg_d(g);
    localparam int XN = XW / XD;

    logic   xbusy;
    state_t xstate;
    mult_iter_pipe_if #(.WIDTH(XW)) xbus ();

    mult_iter_pipe #(.WIDTH(XW), .DIGIT(XD)) xdut (
      .clk         (clk),
      .rst         (rst_x),
      .flush       (1'b0),
      .bus         (xbus),
      .busy        (xbusy),
      .dbg_state_o (xstate)
    );

    initial begin
      xbus.in_valid  = 1'b0;
      xbus.in_a      = '0;
      xbus.in_b      = '0;
      xbus.out_ready = 1'b1;
      @(negedge rst_x);
      while (!stop_x) begin
        @(posedge clk);
        #1;
        xbus.in_valid  = ($urandom_range(0, 3) != 0);
        xbus.in_a      = XW'(pick(XW));
        xbus.in_b      = XW'(pick(XW));
        xbus.out_ready = ($urandom_range(0, 3) != 0);
      end
      xbus.in_valid = 1'b0;
    end

    logic [2*XW-1:0] xq[$];
    int              xdue[$];
    logic [2*XW-1:0] xlast = '0;
    bit              xidle, xv;

    always @(negedge clk) begin
      if (rst_x) begin
        xq.delete();
        xdue.delete();
        xlast = '0;
      end else begin
        xidle = (xq.size() == 0);
        xv    = !xidle && (cyc >= xdue[0]);
        if (xv) xlast = xq[0];
        check($sformatf("w%0d/d%0d out_valid", XW, XD), 128'(xbus.out_valid), 128'(xv));
        check($sformatf("w%0d/d%0d out_p", XW, XD), 128'(xbus.out_p), 128'(xlast));
        check($sformatf("w%0d/d%0d busy", XW, XD), 128'(xbusy), 128'(!xidle));
        check($sformatf("w%0d/d%0d idle", XW, XD), 128'(xstate == IDLE), 128'(xidle));
        if (xv && xbus.out_ready) begin
          void'(xq.pop_front());
          void'(xdue.pop_front());
        end
        if (xidle && xbus.in_valid) begin
          xq.push_back((2*XW)'(xbus.in_a) * (2*XW)'(xbus.in_b));
          xdue.push_back(cyc + 1 + XN);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int k;
    bit seen;
    rst           = 1'b1;
    rst_x         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    rst_x = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", 128'(bus.in_ready), 128'(1));
    check("post-reset state", 128'(dbg_state), 128'(IDLE));
    check("post-reset out_p", 128'(bus.out_p), 128'(0));
    @(posedge clk);
    #1;

    // All-ones, single high bits, and zero operands at normal latency.
    run_op("ones", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
    run_op("msb", 24'h800000, 24'h800000, 48'h400000000000);
    run_op("zeroA", 24'h000000, 24'hABCDEF, 48'h0);

    // Backpressure: product held while out_ready is low.
    bus.out_ready = 1'b0;
    send(24'hFFFFFF, 24'h000002);
    seen = 1'b0;
    for (k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    if (!seen) fail_now("bp out_valid");
    repeat (10) begin
      @(negedge clk);
      check("bp out_valid held", 128'(bus.out_valid), 128'(1));
      check("bp out_p held", 128'(bus.out_p), 128'(48'h1FFFFFE));
      check("bp in_ready", 128'(bus.in_ready), 128'(0));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp release state", 128'(dbg_state), 128'(IDLE));
    check("bp release out_valid", 128'(bus.out_valid), 128'(0));
    check("bp kept out_p", 128'(bus.out_p), 128'(48'h1FFFFFE));
    @(posedge clk);
    #1;

    // Flush during the second BUSY cycle with a competing operand.
    send(24'h000003, 24'h000005);
    @(posedge clk);
    #1;
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a     = 24'h111111;
    bus.in_b     = 24'h000002;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush state", 128'(dbg_state), 128'(IDLE));
    check("flush in_ready", 128'(bus.in_ready), 128'(1));
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | bus.out_valid;
    end
    check("flush no product", 128'(seen), 128'(0));
    check("flush out_p kept", 128'(bus.out_p), 128'(48'h1FFFFFE));
    @(posedge clk);
    #1;
    run_op("after flush", 24'h000007, 24'h000009, 48'd63);

    // Asynchronous reset pulse mid-operation.
    send(24'hABCDEF, 24'h123456);
    @(posedge clk);
    #3 rst = 1'b1;
    #4 rst = 1'b0;
    @(negedge clk);
    check("rst pulse out_valid", 128'(bus.out_valid), 128'(0));
    check("rst pulse in_ready", 128'(bus.in_ready), 128'(1));
    check("rst pulse out_p", 128'(bus.out_p), 128'(0));
    @(posedge clk);
    #1;
    // 0x123456 * 0x654321 = 1193046 * 6636321 = 7917436223766
    run_op("after rst", 24'h123456, 24'h654321, 48'h07336BF94116);

    // Randomised traffic with backpressure, gaps and occasional flush.
    for (int i = 0; i < 12000; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_a      = W'(pick(W));
      bus.in_b      = W'(pick(W));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      flush         = ($urandom_range(0, 49) == 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    flush         = 1'b0;
    stop_x        = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
